// File: rtl/sync_fifo_reg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_reg
// Description : Single-clock register FIFO, first-word-fall-through output,
//               occupancy count, almost-full/empty thresholds, sync clear.
//               Sticky ovf/udf error flags built only with SYNC_FIFO_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_reg #(
    parameter int DW      = 32,
    parameter int LEN_LOG = 2,
    parameter int LEN     = 1 << LEN_LOG,
    parameter int AF_TH   = LEN - 1,
    parameter int AE_TH   = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLR,
    input  logic                 enq,
    input  logic                 deq,
    input  logic [DW-1:0]        din,
    output logic [DW-1:0]        dot,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [LEN_LOG:0]     count,
    output logic                 ovf,
    output logic                 udf
);

    localparam logic [LEN_LOG:0] C_LEN = LEN[LEN_LOG:0];
    localparam logic [LEN_LOG:0] C_AF  = AF_TH[LEN_LOG:0];
    localparam logic [LEN_LOG:0] C_AE  = AE_TH[LEN_LOG:0];

    logic [DW-1:0]      r_mem [0:LEN-1];
    logic [LEN_LOG-1:0] r_wptr;
    logic [LEN_LOG-1:0] r_rptr;
    logic [LEN_LOG:0]   r_count;
    logic               w_wr_ok;
    logic               w_rd_ok;

    // All flags come from the count register only, never from the pointers.
    assign full         = (r_count == C_LEN);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= C_AF);
    assign almost_empty = (r_count <= C_AE);
    assign count        = r_count;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept enq+deq.
    assign w_wr_ok = enq & (~full | deq);
    assign w_rd_ok = deq & ~empty;

    assign dot = r_mem[r_rptr];

    always_ff @(posedge CLK) begin
        if (w_wr_ok && !CLR) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (CLR) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (CLR) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (enq && full && !deq) begin
                r_ovf <= 1'b1;
            end
            if (deq && empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_reg
// Description : Directed self-checking bench for sync_fifo_reg (LEN=4,
//               AF_TH=3, AE_TH=1); error-flag expectations follow
//               SYNC_FIFO_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_reg;

    localparam int DW      = 8;
    localparam int LEN_LOG = 2;
`ifdef SYNC_FIFO_ERR_EN
    localparam logic C_ERR = 1'b1;
`else
    localparam logic C_ERR = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             CLR;
    logic             enq;
    logic             deq;
    logic [DW-1:0]    din;
    logic [DW-1:0]    dot;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [LEN_LOG:0] count;
    logic             ovf;
    logic             udf;

    int n_tot = 0;
    int n_bad = 0;

    sync_fifo_reg #(
        .DW      (DW),
        .LEN_LOG (LEN_LOG),
        .AF_TH   (3),
        .AE_TH   (1)
    ) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .CLR          (CLR),
        .enq          (enq),
        .deq          (deq),
        .din          (din),
        .dot          (dot),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        enq = 1'b1;
        din = d;
        tick();
        enq = 1'b0;
    endtask

    // Stream table for the wrap/threshold run: {enq, deq} and count after the edge.
    logic [1:0] ops  [0:16] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b01, 2'b01,
                                2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};
    int         cnts [0:16] = '{1, 2, 3, 3, 2, 2, 3, 2, 1, 2, 2, 2, 3, 3, 2, 1, 0};

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] wr_val;
        RST = 1'b1; CLR = 1'b0; enq = 1'b0; deq = 1'b0; din = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        RST = 1'b0;

        // Fill / drain
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        chk("fill_af", almost_full, 1);
        chk("fill_ae", almost_empty, 0);
        deq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_dot", dot, 8'hA0 + 8'(i));
            tick();
        end
        deq = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // First-word-fall-through latency
        push(8'h55);
        chk("fwft_dot", dot, 8'h55);
        chk("fwft_empty", empty, 0);
        chk("fwft_count", count, 1);
        deq = 1'b1; tick(); deq = 1'b0;
        chk("fwft_pop_empty", empty, 1);

        // Full with simultaneous enq+deq
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        enq = 1'b1; deq = 1'b1; din = 8'hB4;
        chk("fd_pop_dot", dot, 8'hA0);
        tick();
        enq = 1'b0; deq = 1'b0;
        chk("fd_count", count, 4);
        chk("fd_full", full, 1);
        deq = 1'b1;
        chk("fd_dot1", dot, 8'hA1); tick();
        chk("fd_dot2", dot, 8'hA2); tick();
        chk("fd_dot3", dot, 8'hA3); tick();
        chk("fd_dot4", dot, 8'hB4); tick();
        deq = 1'b0;
        chk("fd_empty", empty, 1);

        // Overflow / underflow / clear
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        push(8'hCC);
        chk("ovf_count", count, 4);
        chk("ovf_flag", ovf, C_ERR);
        deq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_dot", dot, 8'hA0 + 8'(i));
            tick();
        end
        tick();
        deq = 1'b0;
        chk("udf_count", count, 0);
        chk("udf_empty", empty, 1);
        chk("udf_flag", udf, C_ERR);
        chk("udf_ovf_sticky", ovf, C_ERR);
        CLR = 1'b1; tick(); CLR = 1'b0;
        chk("clr_ovf", ovf, 0);
        chk("clr_udf", udf, 0);

        // Clear beats a concurrent enq
        push(8'hA0);
        enq = 1'b1; din = 8'hEE; CLR = 1'b1;
        tick();
        enq = 1'b0; CLR = 1'b0;
        chk("clr_prio_count", count, 0);
        chk("clr_prio_empty", empty, 1);
        push(8'h77);
        chk("clr_after_dot", dot, 8'h77);
        deq = 1'b1; tick(); deq = 1'b0;

        // Wrap and thresholds over an 11-word stream
        wr_val = 8'h30;
        for (int s = 0; s < 17; s++) begin
            enq = ops[s][1];
            deq = ops[s][0];
            din = wr_val;
            if (deq) begin
                chk("wrap_dot", dot, q[0]);
                void'(q.pop_front());
            end
            if (enq) begin
                q.push_back(wr_val);
                wr_val = wr_val + 8'd1;
            end
            tick();
            enq = 1'b0; deq = 1'b0;
            chk("wrap_count", count, cnts[s]);
            chk("wrap_af", almost_full, (cnts[s] >= 3) ? 1 : 0);
            chk("wrap_ae", almost_empty, (cnts[s] <= 1) ? 1 : 0);
        end
        chk("wrap_words", wr_val, 8'h3B);

        // Asynchronous reset mid-operation
        push(8'hE1); push(8'hE2); push(8'hE3);
        chk("mid_count", count, 3);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        #1 RST = 1'b0;
        push(8'hD1);
        chk("post_rst_dot", dot, 8'hD1);
        chk("post_rst_count", count, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
